// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame width and log2 helper for the UART TX scheduler
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;
  // bit length of v (log2(16) = 5), matching the fractional-divider sizing
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int x = v; x > 0; x = x >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_sched_baud.sv
// baud_tick_gen: fractional accumulator producing one tick per bit period while enabled
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int ClkFrequency = 100000000,
  parameter int Baud = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int AccWidth = log2(ClkFrequency / Baud) + 8;
  localparam int ShiftLimiter = log2(Baud >> (31 - AccWidth));
  localparam int Inc = ((Baud << (AccWidth - ShiftLimiter)) + (ClkFrequency >> (ShiftLimiter + 1)))
                       / (ClkFrequency >> ShiftLimiter);
  localparam logic [AccWidth:0] IncW = (AccWidth + 1)'(Inc);
  logic [AccWidth:0] acc;
  // reload while idle so the first carry lands one full bit after enable rises
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else acc <= enable ? {1'b0, acc[AccWidth-1:0]} + IncW : IncW;
  assign tick = acc[AccWidth];
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter sharing one UART TX line; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ClkFrequency = 100000000,
  parameter int Baud = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   data,
  output logic [N_REQ-1:0]     ack,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 txd
);
  state_t state;
  logic tick, found, take;
  logic [2:0] last, win, cnt;
  logic [UART_DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
  logic par;
`endif
  baud_tick_gen #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_baud (
    .clk(clk), .rst(rst), .enable(busy), .tick(tick)
  );
  // descending scan so the index nearest after last is the one kept
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(last) + i) % N_REQ]) begin
        found = 1'b1;
        win = 3'((int'(last) + i) % N_REQ);
      end
    end
  end
  assign take = found && (state == IDLE || (state == STOP && tick));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      txd <= 1'b1;
      busy <= 1'b0;
      ack <= '0;
      grant_id <= '0;
      last <= 3'(N_REQ - 1);
      shift <= '0;
      cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      ack <= take ? N_REQ'(1) << win : '0;
      if (take) begin
        shift <= data[UART_DATA_BITS*win +: UART_DATA_BITS];
        grant_id <= win;
        last <= win;
        busy <= 1'b1;
        txd <= 1'b0;
        cnt <= '0;
        state <= START;
`ifdef UART_TX_PARITY_EN
        par <= ^data[UART_DATA_BITS*win +: UART_DATA_BITS];
`endif
      end else if (tick) begin
        case (state)
          START: begin
            state <= DATA;
            txd <= shift[0];
          end
          DATA: begin
            shift <= shift >> 1;
            cnt <= cnt + 3'd1;
            if (cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd <= par;
`else
              state <= STOP;
              txd <= 1'b1;
`endif
            end else txd <= shift[1];
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            txd <= 1'b1;
          end
`endif
          STOP: begin
            state <= IDLE;
            busy <= 1'b0;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed vector bench for uart_tx_sched at 16 clocks per bit
module tb_uart_tx_sched;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * 16;
  logic clk = 1'b0, rst = 1'b1, busy, txd;
  logic [3:0] req = '0, ack;
  logic [31:0] data = '0;
  logic [2:0] grant_id;
  int vectors = 0, miscompares = 0, cyc = 0, ack_cyc = 0, prev_cyc = 0, n = 0;
  logic seen;
  typedef struct {
    logic [2:0] id;
    logic [7:0] b;
    logic [9:0] f;
    logic p;
  } vec_t;
  vec_t tbl[4];
  uart_tx_sched #(.N_REQ(4), .ClkFrequency(1600000), .Baud(100000)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .ack(ack),
    .grant_id(grant_id), .busy(busy), .txd(txd)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [10:0] fx(input logic [9:0] f, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, f[8:0]};
`else
    return {1'b0, f};
`endif
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic wait_ack(input logic [2:0] id, output int w);
    w = 0;
    while (ack == '0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    ack_cyc = cyc;
    chk("ack", 32'(ack), 32'(4'b1 << id));
    chk("grant_id", 32'(grant_id), 32'(id));
    chk("start_txd", 32'(txd), 32'(0));
    chk("busy_set", 32'(busy), 32'(1));
    req[id] = 1'b0;
  endtask
  task automatic check_frame(input logic [2:0] id, input logic [10:0] exp, input logic rearm, output int w);
    logic [10:0] got = '0;
    wait_ack(id, w);
    if (rearm) begin
      @(negedge clk);
      req[id] = 1'b1;
      repeat (7) @(negedge clk);
    end else repeat (8) @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      got[b] = txd;
      if (b < NB - 1) repeat (16) @(negedge clk);
    end
    chk("frame", 32'(got), 32'(exp));
  endtask
  task automatic check_idle_fall();
    repeat (7) @(negedge clk);
    chk("busy_last_stop", 32'(busy), 32'(1));
    @(negedge clk);
    chk("busy_fall", 32'(busy), 32'(0));
    chk("idle_txd", 32'(txd), 32'(1));
  endtask
  initial begin
    tbl[0] = '{id: 3'd0, b: 8'h55, f: 10'h2AA, p: 1'b0};
    tbl[1] = '{id: 3'd1, b: 8'h0F, f: 10'h21E, p: 1'b0};
    tbl[2] = '{id: 3'd2, b: 8'hF0, f: 10'h3E0, p: 1'b0};
    tbl[3] = '{id: 3'd3, b: 8'h81, f: 10'h302, p: 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_grant", 32'(grant_id), 32'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      data[8*tbl[v].id +: 8] = tbl[v].b;
      req[tbl[v].id] = 1'b1;
      check_frame(tbl[v].id, fx(tbl[v].f, tbl[v].p), 1'b0, n);
      chk("latency", 32'(n), 32'(1));
      check_idle_fall();
      repeat (5) @(negedge clk);
    end
    data = 32'hA3A2A1A0;
    req = 4'hF;
    check_frame(3'd0, fx(10'h340, 1'b0), 1'b0, n);
    prev_cyc = ack_cyc;
    check_frame(3'd1, fx(10'h342, 1'b1), 1'b0, n);
    chk("gap01", 32'(ack_cyc - prev_cyc), 32'(FRAME));
    prev_cyc = ack_cyc;
    check_frame(3'd2, fx(10'h344, 1'b1), 1'b0, n);
    chk("gap12", 32'(ack_cyc - prev_cyc), 32'(FRAME));
    prev_cyc = ack_cyc;
    check_frame(3'd3, fx(10'h346, 1'b0), 1'b0, n);
    chk("gap23", 32'(ack_cyc - prev_cyc), 32'(FRAME));
    check_idle_fall();
    repeat (5) @(negedge clk);
    data = 32'h00220011;
    req = 4'b0101;
    check_frame(3'd0, fx(10'h222, 1'b0), 1'b1, n);
    check_frame(3'd2, fx(10'h244, 1'b0), 1'b1, n);
    check_frame(3'd0, fx(10'h222, 1'b0), 1'b0, n);
    check_frame(3'd2, fx(10'h244, 1'b0), 1'b0, n);
    check_idle_fall();
    repeat (5) @(negedge clk);
    data = 32'h0000993C;
    req[0] = 1'b1;
    fork
      check_frame(3'd0, fx(10'h278, 1'b0), 1'b0, n);
      begin
        repeat (40) @(negedge clk);
        req[1] = 1'b1;
        repeat (5) @(negedge clk);
        req[1] = 1'b0;
      end
    join
    seen = 1'b0;
    repeat (48) begin
      @(negedge clk);
      seen = seen | (|ack);
    end
    chk("withdrawn_ack", 32'(seen), 32'(0));
    chk("withdrawn_busy", 32'(busy), 32'(0));
    chk("withdrawn_txd", 32'(txd), 32'(1));
    data = 32'h5A000000;
    req[2] = 1'b1;
    wait_ack(3'd2, n);
    repeat (72) @(negedge clk);
    chk("bit3_txd", 32'(txd), 32'(0));
    #2 rst = 1'b1;
    #1;
    chk("async_txd", 32'(txd), 32'(1));
    chk("async_busy", 32'(busy), 32'(0));
    chk("async_ack", 32'(ack), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_grant", 32'(grant_id), 32'(0));
    chk("post_rst_txd", 32'(txd), 32'(1));
    req[3] = 1'b1;
    check_frame(3'd3, fx(10'h2B4, 1'b0), 1'b0, n);
    check_idle_fall();
`ifdef UART_TX_PARITY_EN
    repeat (5) @(negedge clk);
    data = 32'h00000007;
    req[0] = 1'b1;
    check_frame(3'd0, 11'h60E, 1'b0, n);
    check_idle_fall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
